// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, architectural status codes
// and the sequential controller's state encoding.
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXECUTE = 4'd3,
        S_MEMORY  = 4'd4,
        S_WB      = 4'd5,
        S_PCUPD   = 4'd6,
        S_HALTED  = 4'd7
    } state_t;

    // Register-file write-back; cmov's condition is applied downstream.
    function automatic logic writes_reg(input logic [3:0] icode);
        logic w;
        case (icode)
            I_CMOV, I_IRMOV, I_MRMOV, I_OPQ,
            I_CALL, I_RET, I_PUSH, I_POP:       w = 1'b1;
            I_HALT, I_NOP, I_RMMOV, I_JXX:      w = 1'b0;
            default:                            w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic writes_mem(input logic [3:0] icode);
        return (icode == I_RMMOV) || (icode == I_CALL) || (icode == I_PUSH);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle stage sequencer for the sequential Y86-64 core: one stage per
// clock, write strobes, architectural status, watchdog and counters.
module seq_stage_controller
    import y86_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             dmem_error,
    output logic             en_fetch,
    output logic             en_decode,
    output logic             en_execute,
    output logic             en_memory,
    output logic             en_wb,
    output logic             cc_we,
    output logic             mem_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic [2:0]       stat,
    output logic             running,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    state_t state_q, state_d;
    stat_t  stat_q, stat_d;
    logic   timeout_q, timeout_d;

    logic             watchdog_hit;
    logic [1:0]       cnt_en;
    logic [CNT_W-1:0] cnt_val [2];

    // The edge that takes cycle_count to MAX_CYCLES is also the edge that halts.
    assign watchdog_hit = running && (cycle_count >= CNT_W'(MAX_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        stat_d     = stat_q;
        timeout_d  = timeout_q;
        en_fetch   = 1'b0;
        en_decode  = 1'b0;
        en_execute = 1'b0;
        en_memory  = 1'b0;
        en_wb      = 1'b0;
        cc_we      = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        pc_we      = 1'b0;
        running    = 1'b1;
        cnt_en     = 2'b00;

        case (state_q)
            S_IDLE: begin
                running = 1'b0;
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                en_fetch = 1'b1;
                if (imem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = S_HALTED;
                end else if (!instr_valid) begin
                    stat_d  = STAT_INS;
                    state_d = S_HALTED;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                en_decode = 1'b1;
                if (icode == I_HALT) begin
                    stat_d    = STAT_HLT;
                    state_d   = S_HALTED;
                    cnt_en[1] = 1'b1;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                en_execute = 1'b1;
                cc_we      = (icode == I_OPQ);
                state_d    = S_MEMORY;
            end
            S_MEMORY: begin
                en_memory = 1'b1;
                mem_we    = writes_mem(icode);
                if (dmem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = S_HALTED;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                en_wb   = 1'b1;
                reg_we  = writes_reg(icode);
                state_d = S_PCUPD;
            end
            S_PCUPD: begin
                pc_we     = 1'b1;
                cnt_en[1] = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALTED: begin
                running = 1'b0;
            end
            default: begin
                running = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        cnt_en[0] = running;
        if (watchdog_hit) begin
            state_d   = S_HALTED;
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            stat_q    <= STAT_AOK;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stat_q    <= stat_d;
            timeout_q <= timeout_d;
        end
    end

    // Index 0 counts stage cycles, index 1 counts retired instructions.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk     (clk),
            .clr_i   (rst),
            .en_i    (cnt_en[gi]),
            .count_o (cnt_val[gi])
        );
    end

    assign cycle_count = cnt_val[0];
    assign instr_count = cnt_val[1];
    assign stat        = stat_q;
    assign timeout     = timeout_q;

endmodule
